// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared definitions for the streaming 3-bit decoder.
//   CODE_W  : width of the incoming code
//   state_t : occupancy state of the two-entry output buffer
//             (EMPTY / ONE word held / TWO words held)
// Optional feature macro used by decoder_stream: DECODER_STATS_EN
package decoder_pkg;

  localparam int CODE_W = 3;

  // 2'd3 is never entered on purpose; the FSM treats it as EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_lut.sv
// decoder_lut
// Purely combinational code-to-value table: code c maps to c+1,
// zero-extended to OUT_W bits (3'b000 -> 1, 3'b111 -> 8).
// Ports:
//   i_code  [CODE_W-1:0] : code to decode
//   o_value [OUT_W-1:0]  : decoded value
module decoder_lut
  import decoder_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [CODE_W-1:0] i_code,
  output logic [OUT_W-1:0]  o_value
);

  logic [3:0] w_nib;

  // Every code is legal, so the table is full; the default only keeps
  // the block latch-free.
  always_comb begin
    w_nib = 4'd0;
    case (i_code)
      3'd0:    w_nib = 4'd1;
      3'd1:    w_nib = 4'd2;
      3'd2:    w_nib = 4'd3;
      3'd3:    w_nib = 4'd4;
      3'd4:    w_nib = 4'd5;
      3'd5:    w_nib = 4'd6;
      3'd6:    w_nib = 4'd7;
      3'd7:    w_nib = 4'd8;
      default: w_nib = 4'd0;
    endcase
  end

  assign o_value = OUT_W'(w_nib);

endmodule

// File: rtl/decoder_stream.sv
// decoder_stream
// Streaming decoder with valid/ready on both sides and a two-entry skid
// buffer so the upstream can run at one code per cycle even though
// in_ready is a registered signal.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : upstream code valid
//   in_ready   : decoder accepts a code this cycle (registered)
//   in_code    : 3-bit code
//   out_valid  : out_data holds a decoded word
//   out_ready  : downstream accepts this cycle
//   out_data   : decoded value (code + 1, zero-extended to OUT_W)
//   dec_count  : saturating count of delivered words
//                (only when DECODER_STATS_EN is defined)
// Configuration macro: DECODER_STATS_EN
module decoder_stream
  import decoder_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
`ifdef DECODER_STATS_EN
  ,
  output logic [CNT_W-1:0]  dec_count
`endif
);

  // Width sanity: the largest decoded value (8) needs four bits.
  if (OUT_W < 4) begin : g_badOutW
    $error("decoder_stream: OUT_W must be at least 4");
  end
  if (CNT_W < 1) begin : g_badCntW
    $error("decoder_stream: CNT_W must be at least 1");
  end

  state_t            r_state;
  state_t            w_nextState;
  logic [OUT_W-1:0]  r_mainQ;
  logic [OUT_W-1:0]  r_skidQ;
  logic              r_inReady;
  logic              r_outValid;
  logic [OUT_W-1:0]  w_dec;
  logic              w_accept;
  logic              w_xfer;

  decoder_lut #(
    .OUT_W (OUT_W)
  ) u_lut (
    .i_code  (in_code),
    .o_value (w_dec)
  );

  assign w_accept  = in_valid && r_inReady;
  assign w_xfer    = r_outValid && out_ready;
  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_data  = r_mainQ;

  // Next occupancy. in_ready and out_valid are registered copies of
  // properties of this value, so they line up with the state register.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) w_nextState = ST_ONE;
      end
      ST_ONE: begin
        if (w_accept && !w_xfer)      w_nextState = ST_TWO;
        else if (!w_accept && w_xfer) w_nextState = ST_EMPTY;
      end
      ST_TWO: begin
        if (w_xfer) w_nextState = ST_ONE;
      end
      default: w_nextState = ST_EMPTY;
    endcase
  end

  // Buffer FSM and datapath. main_q always holds the older word, skid_q
  // the younger one. In ONE, a simultaneous accept and transfer loads
  // the new word straight into main_q so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_mainQ    <= '0;
      r_skidQ    <= '0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_inReady  <= (w_nextState != ST_TWO);
      r_outValid <= (w_nextState == ST_ONE) || (w_nextState == ST_TWO);
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) r_mainQ <= w_dec;
        end
        ST_ONE: begin
          if (w_accept && w_xfer) r_mainQ <= w_dec;
          else if (w_accept)      r_skidQ <= w_dec;
        end
        ST_TWO: begin
          if (w_xfer) r_mainQ <= r_skidQ;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DECODER_STATS_EN
  logic [CNT_W-1:0] r_decCount;

  // Delivered-word counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_decCount <= '0;
    end else if (w_xfer && (r_decCount != {CNT_W{1'b1}})) begin
      r_decCount <= r_decCount + CNT_W'(1);
    end
  end

  assign dec_count = r_decCount;
`endif

endmodule

// File: tb/tb_decoder_stream.sv
// tb_decoder_stream
// Self-checking bench for decoder_stream. The reference is a plain
// two-deep FIFO of expected values (code + 1): out_valid means "queue
// non-empty", in_ready means "fewer than two words held", and every
// transfer must deliver the queue head.
module tb_decoder_stream;

  localparam int OW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_code;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
`ifdef DECODER_STATS_EN
  logic [CW-1:0] dec_count;
`endif

  int            checks = 0;
  int            errors = 0;
  int            delivered = 0;
  logic [OW-1:0] model[$];

  decoder_stream #(
    .OUT_W (OW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DECODER_STATS_EN
    ,
    .dec_count (dec_count)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Synchronous reset for one edge; the model forgets everything.
  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model.delete();
    delivered = 0;
    checkOutput("rstOutValid", out_valid, 1'b0);
    checkOutput("rstOutData", out_data, '0);
    checkOutput("rstInReady", in_ready, 1'b0);
`ifdef DECODER_STATS_EN
    checkOutput("rstDecCount", dec_count, '0);
`endif
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs, update the model from the handshakes that
  // happen on the next edge, then check every output after that edge.
  task automatic applyStimulus(input logic v, input logic [2:0] c,
                               input logic r, output logic accepted);
    logic xfer;
    int   expCnt;
    in_valid  = v;
    in_code   = c;
    out_ready = r;
    #1;
    accepted = v && in_ready;
    xfer     = out_valid && out_ready;
    if (xfer && model.size() != 0) begin
      checkOutput("xferData", out_data, model.pop_front());
      delivered++;
    end
    if (accepted) model.push_back(OW'(c) + OW'(1));
    @(posedge clk);
    #1;
    checkOutput("outValid", out_valid, model.size() != 0);
    checkOutput("inReady", in_ready, model.size() < 2);
    if (model.size() != 0) checkOutput("outData", out_data, model[0]);
`ifdef DECODER_STATS_EN
    expCnt = (delivered > 15) ? 15 : delivered;
    checkOutput("decCount", dec_count, expCnt);
`else
    expCnt = 0;
`endif
  endtask

  initial begin
    logic acc;
    logic curValid;
    logic [2:0] curCode;
    int   sent;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = 3'd0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset values, then in_ready comes up one cycle after rst drops.
    doReset();
    applyStimulus(1'b0, 3'd0, 1'b1, acc);
    checkOutput("readyAfterRst", in_ready, 1'b1);

    // First code: visible one cycle after accept.
    applyStimulus(1'b1, 3'd0, 1'b1, acc);
    checkOutput("firstData", out_data, 8'h01);
    applyStimulus(1'b0, 3'd0, 1'b1, acc);

    // Back-to-back stream of all codes at full rate.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 1'b1, acc);
      checkOutput("streamData", out_data, 8'(i + 1));
      checkOutput("streamAcc", acc, 1'b1);
    end
    applyStimulus(1'b0, 3'd0, 1'b1, acc);

    // Backpressure fills both entries; head stays stable.
    applyStimulus(1'b1, 3'd3, 1'b0, acc);
    applyStimulus(1'b1, 3'd5, 1'b0, acc);
    checkOutput("twoInReady", in_ready, 1'b0);
    checkOutput("twoHold", out_data, 8'h04);
    applyStimulus(1'b1, 3'd6, 1'b0, acc);
    checkOutput("ignoredWhileFull", acc, 1'b0);
    checkOutput("twoHoldAgain", out_data, 8'h04);
    applyStimulus(1'b0, 3'd0, 1'b1, acc);
    checkOutput("drainSecond", out_data, 8'h06);
    checkOutput("drainReady", in_ready, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1, acc);

    // Reset while holding two words: both are discarded.
    applyStimulus(1'b1, 3'd1, 1'b0, acc);
    applyStimulus(1'b1, 3'd2, 1'b0, acc);
    checkOutput("preRstFull", in_ready, 1'b0);
    doReset();
    applyStimulus(1'b0, 3'd0, 1'b1, acc);
    applyStimulus(1'b0, 3'd0, 1'b1, acc);
    checkOutput("noOldWords", out_valid, 1'b0);

    // Random traffic with a well-behaved upstream that holds its code.
    sent     = 0;
    curValid = 1'b0;
    curCode  = 3'd0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      if (!curValid) begin
        curValid = ($urandom_range(0, 3) != 0);
        curCode  = 3'($urandom);
      end
      applyStimulus(curValid, curCode, 1'($urandom_range(0, 3) != 0), acc);
      if (acc) begin
        sent++;
        curValid = 1'b0;
      end
    end
    checkOutput("randSentAll", sent, 10000);
    for (int cyc = 0; cyc < 10 && model.size() != 0; cyc++) begin
      applyStimulus(1'b0, 3'd0, 1'b1, acc);
    end
    checkOutput("randDrained", model.size(), 0);

`ifdef DECODER_STATS_EN
    // Saturating counter: 20 deliveries, sticks at 4'hF from the 15th.
    doReset();
    applyStimulus(1'b0, 3'd0, 1'b1, acc);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 3'(i % 8), 1'b1, acc);
    end
    applyStimulus(1'b0, 3'd0, 1'b1, acc);
    checkOutput("satDelivered", delivered, 20);
    checkOutput("satCount", dec_count, 4'hF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
